fifo_wr_ctrl: RTL and testbench

FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

---
 rtl/fifo_wr_ctrl.sv | 76 +++++++
 tb/tb_fifo_wr_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of an asynchronous FIFO: Gray write pointer, registered full flag and write-side occupancy.
// Optional sticky overflow flag is compiled in with `define FIFO_WR_OVERFLOW_EN.
module fifo_wr_ctrl #(
  parameter int  FIFO_DEPTH = 16,
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic          wr_clk,
  input  logic          wr_rst,
  input  logic          wr_en,
  input  logic [AW:0]   rd_ptr_gray_sync,
  output logic          mem_we,
  output logic [AW-1:0] wr_addr,
  output logic [AW:0]   wr_ptr_gray,
  output logic          full,
  output logic [AW:0]   wr_level
`ifdef FIFO_WR_OVERFLOW_EN
  ,
  output logic          overflow
`endif
);

  logic [AW:0] wr_bin;
  logic [AW:0] wr_bin_next;
  logic [AW:0] wr_gray_next;
  logic [AW:0] rd_bin_sync;
  logic [AW:0] full_pattern;
  logic        full_next;

  // MSB-down XOR prefix; the loop variable is local so the function stays combinational.
  function automatic logic [AW:0] gray2bin(input logic [AW:0] gray);
    logic [AW:0] bin;
    bin[AW] = gray[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  // Writes are blocked during reset so the storage array never sees a stray strobe.
  assign mem_we       = wr_en & ~full & ~wr_rst;
  assign wr_addr      = wr_bin[AW-1:0];
  assign wr_bin_next  = wr_bin + {{AW{1'b0}}, mem_we};
  assign wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1);
  assign rd_bin_sync  = gray2bin(rd_ptr_gray_sync);

  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted, rest equal.
  assign full_pattern = {~rd_ptr_gray_sync[AW:AW-1], rd_ptr_gray_sync[AW-2:0]};
  assign full_next    = (wr_gray_next == full_pattern);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      wr_bin      <= '0;
      wr_ptr_gray <= '0;
      full        <= 1'b0;
      wr_level    <= '0;
    end else begin
      wr_bin      <= wr_bin_next;
      wr_ptr_gray <= wr_gray_next;
      full        <= full_next;
      wr_level    <= wr_bin_next - rd_bin_sync;
    end
  end

`ifdef FIFO_WR_OVERFLOW_EN
  // Sticky: records any write attempt that was refused because the FIFO was full.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: directed scenarios plus randomized traffic against
// a count-based occupancy model (writes accepted minus reads seen).
module tb_fifo_wr_ctrl;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int PMOD  = 2 * DEPTH;

  logic          wr_clk = 1'b0;
  logic          wr_rst = 1'b1;
  logic          wr_en  = 1'b0;
  logic [AW:0]   rd_ptr_gray_sync = '0;
  logic          mem_we;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   wr_ptr_gray;
  logic          full;
  logic [AW:0]   wr_level;
`ifdef FIFO_WR_OVERFLOW_EN
  logic          overflow;
`endif

  fifo_wr_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .wr_clk           (wr_clk),
    .wr_rst           (wr_rst),
    .wr_en            (wr_en),
    .rd_ptr_gray_sync (rd_ptr_gray_sync),
    .mem_we           (mem_we),
    .wr_addr          (wr_addr),
    .wr_ptr_gray      (wr_ptr_gray),
    .full             (full),
    .wr_level         (wr_level)
`ifdef FIFO_WR_OVERFLOW_EN
    ,
    .overflow         (overflow)
`endif
  );

  always #5 wr_clk = ~wr_clk;

  // Reference model: total writes accepted and total reads observed since reset.
  int wr_cnt    = 0;
  int rd_cnt    = 0;
  int exp_level = 0;
  bit exp_full  = 1'b0;
  bit exp_ovf   = 1'b0;

  int checks = 0;
  int errors = 0;

  function automatic logic [AW:0] to_gray(input int count);
    int p;
    p = count % PMOD;
    return (AW+1)'(p ^ (p / 2));
  endfunction

  function automatic logic [AW:0] exp_gray();
    return to_gray(wr_cnt);
  endfunction

  function automatic logic [AW-1:0] exp_addr();
    return (AW)'(wr_cnt % DEPTH);
  endfunction

  function automatic bit exp_we();
    return wr_en && !exp_full && !wr_rst;
  endfunction

  // Apply inputs on the falling edge, settle, leave the combinational outputs ready to sample.
  task automatic drive(input bit we, input int rd, input bit rst);
    @(negedge wr_clk);
    wr_en            = we;
    wr_rst           = rst;
    rd_cnt           = rd;
    rd_ptr_gray_sync = to_gray(rd);
    #1;
  endtask

  // Advance one rising edge and update the model from occupancy arithmetic.
  task automatic tick();
    bit accept;
    bit refused;
    accept  = wr_en && !exp_full && !wr_rst;
    refused = wr_en && exp_full && !wr_rst;
    @(posedge wr_clk);
    #1;
    if (wr_rst) begin
      wr_cnt    = 0;
      exp_level = 0;
      exp_full  = 1'b0;
      exp_ovf   = 1'b0;
    end else begin
      if (accept) wr_cnt++;
      exp_level = wr_cnt - rd_cnt;
      exp_full  = (exp_level == DEPTH);
      exp_ovf   = exp_ovf | refused;
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 0, 1'b1);
    tick();
    rd_cnt = 0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 0, 1'b1);
      checks++;
      if (mem_we !== 1'b0) begin
        errors++;
        $display("FAIL reset_mem_we: got %b want 0", mem_we);
      end
      tick();
    end
    checks++;
    if (wr_ptr_gray !== '0 || full !== 1'b0 || wr_level !== '0 || wr_addr !== '0) begin
      errors++;
      $display("FAIL reset_state: gray=%h full=%b level=%0d addr=%0d want all 0",
               wr_ptr_gray, full, wr_level, wr_addr);
    end
`ifdef FIFO_WR_OVERFLOW_EN
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_overflow: got %b want 0", overflow);
    end
`endif
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 0, 1'b0);
      checks++;
      if (mem_we !== 1'b1 || wr_addr !== exp_addr()) begin
        errors++;
        $display("FAIL fill_write[%0d]: mem_we=%b addr=%0d want 1/%0d", i, mem_we, wr_addr, exp_addr());
      end
      tick();
      checks++;
      if (full !== exp_full || wr_level !== (AW+1)'(exp_level) || wr_ptr_gray !== exp_gray()) begin
        errors++;
        $display("FAIL fill_state[%0d]: full=%b level=%0d gray=%h want %b/%0d/%h",
                 i, full, wr_level, wr_ptr_gray, exp_full, exp_level, exp_gray());
      end
    end
    checks++;
    if (full !== 1'b1 || wr_ptr_gray !== 5'h18 || wr_level !== 5'd16) begin
      errors++;
      $display("FAIL fill_final: full=%b gray=%h level=%0d want 1/18/16", full, wr_ptr_gray, wr_level);
    end
  endtask

  task automatic test_blocked();
    drive(1'b1, 0, 1'b0);
    checks++;
    if (mem_we !== 1'b0) begin
      errors++;
      $display("FAIL blocked_mem_we: got %b want 0", mem_we);
    end
    tick();
    checks++;
    if (wr_ptr_gray !== 5'h18 || full !== 1'b1 || wr_level !== 5'd16) begin
      errors++;
      $display("FAIL blocked_state: gray=%h full=%b level=%0d want 18/1/16", wr_ptr_gray, full, wr_level);
    end
`ifdef FIFO_WR_OVERFLOW_EN
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL blocked_overflow: got %b want 1", overflow);
    end
`endif
  endtask

  task automatic test_drain_release();
    drive(1'b0, 1, 1'b0);
    tick();
    checks++;
    if (full !== 1'b0 || wr_level !== 5'd15) begin
      errors++;
      $display("FAIL drain_release: full=%b level=%0d want 0/15", full, wr_level);
    end
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 2, 1'b0);
    checks++;
    if (mem_we !== 1'b1 || wr_addr !== '0) begin
      errors++;
      $display("FAIL simul_write: mem_we=%b addr=%0d want 1/0", mem_we, wr_addr);
    end
    tick();
    checks++;
    if (full !== 1'b0 || wr_level !== 5'd15 || wr_ptr_gray !== exp_gray()) begin
      errors++;
      $display("FAIL simul_state: full=%b level=%0d gray=%h want 0/15/%h",
               full, wr_level, wr_ptr_gray, exp_gray());
    end
`ifdef FIFO_WR_OVERFLOW_EN
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL simul_overflow_sticky: got %b want 1", overflow);
    end
`endif
  endtask

  task automatic test_reset_mid_fill();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 0, 1'b0);
      tick();
    end
    checks++;
    if (wr_level !== 5'd9) begin
      errors++;
      $display("FAIL midfill_level: got %0d want 9", wr_level);
    end
    drive(1'b1, 0, 1'b1);
    checks++;
    if (mem_we !== 1'b0) begin
      errors++;
      $display("FAIL midfill_mem_we: got %b want 0", mem_we);
    end
    tick();
    checks++;
    if (wr_ptr_gray !== '0 || full !== 1'b0 || wr_level !== '0 || wr_addr !== '0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL midfill_reset: gray=%h full=%b level=%0d addr=%0d we=%b want all 0",
               wr_ptr_gray, full, wr_level, wr_addr, mem_we);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 0, 1'b0);
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, wr_cnt - 1, 1'b0);
      checks++;
      if (mem_we !== 1'b1 || wr_addr !== exp_addr()) begin
        errors++;
        $display("FAIL wrap_write[%0d]: mem_we=%b addr=%0d want 1/%0d", i, mem_we, wr_addr, exp_addr());
      end
      tick();
      checks++;
      if (wr_level !== 5'd2 || full !== 1'b0 || wr_ptr_gray !== exp_gray()) begin
        errors++;
        $display("FAIL wrap_state[%0d]: level=%0d full=%b gray=%h want 2/0/%h",
                 i, wr_level, full, wr_ptr_gray, exp_gray());
      end
    end
  endtask

  task automatic test_random();
    int rd;
    bit we;
    bit rst;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      we  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 79) == 0);
      rd  = rd_cnt;
      if (rd < wr_cnt && $urandom_range(0, 2) == 0) rd++;
      if (rst) rd = 0;
      drive(we, rd, rst);
      checks++;
      if (mem_we !== exp_we() || wr_addr !== exp_addr()) begin
        errors++;
        $display("FAIL rand_write[%0d]: mem_we=%b addr=%0d want %b/%0d",
                 i, mem_we, wr_addr, exp_we(), exp_addr());
      end
      tick();
      checks++;
      if (full !== exp_full || wr_level !== (AW+1)'(exp_level) || wr_ptr_gray !== exp_gray()) begin
        errors++;
        $display("FAIL rand_state[%0d]: full=%b level=%0d gray=%h want %b/%0d/%h",
                 i, full, wr_level, wr_ptr_gray, exp_full, exp_level, exp_gray());
      end
`ifdef FIFO_WR_OVERFLOW_EN
      checks++;
      if (overflow !== exp_ovf) begin
        errors++;
        $display("FAIL rand_overflow[%0d]: got %b want %b", i, overflow, exp_ovf);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_blocked();
    test_drain_release();
    test_simultaneous();
    test_reset_mid_fill();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
